// File: rtl/span_cme_pkg.sv
// Shared constants, register offsets and FSM state type for the SPAN scan-risk engine.
package span_cme_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_CON  = 5;
  localparam int NUM_SCEN = 7;

  localparam logic [4:0] OFF_P      = 5'd0;
  localparam logic [4:0] OFF_Q0     = 5'd1;
  localparam logic [4:0] OFF_PCT    = 5'd6;
  localparam logic [4:0] OFF_S0     = 5'd9;
  localparam logic [4:0] OFF_LAST   = 5'd28;
  localparam logic [4:0] OFF_RESULT = 5'd29;
  localparam logic [4:0] OFF_STATUS = 5'd30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RANGE = 3'd1,
    ST_SUM   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_FIN   = 3'd4
  } scan_state_e;

  // Clamp an unsigned 32-bit quantity into 16 bits.
  function automatic logic [15:0] sat_u16_u32(input logic [31:0] v);
    if (v > 32'd65535) begin
      return 16'hFFFF;
    end else begin
      return v[15:0];
    end
  endfunction

  // Clamp a signed 64-bit quantity into the unsigned range 0..0xFFFF.
  function automatic logic [15:0] sat_u16_s64(input logic signed [63:0] v);
    if (v < 64'sd0) begin
      return 16'h0000;
    end else if (v > 64'sd65535) begin
      return 16'hFFFF;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/span_scan_unit.sv
// Sequential scan-risk datapath: price range, position delta sum, scenario scan and final clamp.
module span_scan_unit
  import span_cme_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_price,
  input  logic [15:0] i_pct,
  input  logic [79:0] i_q_flat,
  input  logic [79:0] i_s_flat,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_range,
  output logic [15:0] o_result
);

  scan_state_e        r_state;
  scan_state_e        w_next_state;
  logic [2:0]         r_cnt;
  logic [15:0]        r_range;
  logic [15:0]        r_result;
  logic               r_done;
  logic signed [39:0] r_acc;
  logic signed [63:0] r_max_loss;

  logic [31:0]        w_prod;
  logic [31:0]        w_quot;
  logic [15:0]        w_q;
  logic [15:0]        w_s;
  logic signed [39:0] w_term;
  logic signed [19:0] w_k_ext;
  logic signed [19:0] w_r_ext;
  logic signed [19:0] w_kr;
  logic signed [19:0] w_m;
  logic signed [63:0] w_loss;

  localparam logic [2:0] SUM_LAST  = 3'(NUM_CON - 1);
  localparam logic [2:0] SCAN_LAST = 3'(NUM_SCEN - 1);

  // Price range: unsigned 32-bit product, truncating divide by 100.
  assign w_prod = {16'd0, i_price} * {16'd0, i_pct};
  assign w_quot = w_prod / 32'd100;

  // Select the contract addressed by the step counter during the sum phase.
  always_comb begin
    w_q = 16'd0;
    w_s = 16'd0;
    case (r_cnt)
      3'd0:    begin w_q = i_q_flat[15:0];  w_s = i_s_flat[15:0];  end
      3'd1:    begin w_q = i_q_flat[31:16]; w_s = i_s_flat[31:16]; end
      3'd2:    begin w_q = i_q_flat[47:32]; w_s = i_s_flat[47:32]; end
      3'd3:    begin w_q = i_q_flat[63:48]; w_s = i_s_flat[63:48]; end
      3'd4:    begin w_q = i_q_flat[79:64]; w_s = i_s_flat[79:64]; end
      default: begin w_q = 16'd0;           w_s = 16'd0;           end
    endcase
  end

  // Signed position times unsigned sensitivity.
  assign w_term = $signed({{24{w_q[15]}}, w_q}) * $signed({24'd0, w_s});

  // Scenario k = cnt-3, move m_k = k*R/3 (signed divide truncates toward zero), loss = -D*m_k.
  assign w_k_ext = $signed({17'd0, r_cnt}) - 20'sd3;
  assign w_r_ext = $signed({4'd0, r_range});
  assign w_kr    = w_k_ext * w_r_ext;
  assign w_m     = w_kr / 20'sd3;
  assign w_loss  = -($signed({{24{r_acc[39]}}, r_acc}) * $signed({{44{w_m[19]}}, w_m}));

  // Next-state logic for the calculation sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_RANGE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RANGE: w_next_state = ST_SUM;
      ST_SUM: begin
        if (r_cnt == SUM_LAST) begin
          w_next_state = ST_SCAN;
        end else begin
          w_next_state = ST_SUM;
        end
      end
      ST_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_state = ST_SCAN;
        end
      end
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Step counter for contracts in SUM and scenarios in SCAN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_SUM:  r_cnt <= (r_cnt == SUM_LAST)  ? 3'd0 : r_cnt + 3'd1;
        ST_SCAN: r_cnt <= (r_cnt == SCAN_LAST) ? 3'd0 : r_cnt + 3'd1;
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  // Datapath registers: range, accumulator, running worst loss, result and done flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_range    <= 16'd0;
      r_result   <= 16'd0;
      r_done     <= 1'b0;
      r_acc      <= 40'sd0;
      r_max_loss <= 64'sd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc      <= 40'sd0;
            r_max_loss <= 64'sd0;
            r_done     <= 1'b0;
          end else begin
            r_done     <= r_done;
          end
        end
        ST_RANGE: r_range <= sat_u16_u32(w_quot);
        ST_SUM:   r_acc   <= r_acc + w_term;
        ST_SCAN: begin
          if (w_loss > r_max_loss) begin
            r_max_loss <= w_loss;
          end else begin
            r_max_loss <= r_max_loss;
          end
        end
        ST_FIN: begin
          r_result <= sat_u16_s64(r_max_loss);
          r_done   <= 1'b1;
        end
        default: r_done <= r_done;
      endcase
    end
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = r_done;
  assign o_range  = r_range;
  assign o_result = r_result;

endmodule

// File: rtl/span_cme_calc.sv
// Bus-facing top: register file, read mux, start decode and the scan-risk engine.
module span_cme_calc
  import span_cme_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [4:0]        offset,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] priceScanRange
);

  logic [15:0] r_regs [0:28];
  logic [15:0] r_read_data;
  logic [15:0] w_rd_mux;
  logic        w_wr_en;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_range;
  logic [15:0] w_result;
  logic [79:0] w_q_flat;
  logic [79:0] w_s_flat;

  // Writes land only in the 0..28 window and only while the engine is idle.
  assign w_wr_en = chipselect & write & ~w_busy & (offset <= OFF_LAST);
  assign w_start = w_wr_en & (offset == OFF_LAST);

  assign w_q_flat = {r_regs[OFF_Q0 + 5'd4], r_regs[OFF_Q0 + 5'd3], r_regs[OFF_Q0 + 5'd2],
                     r_regs[OFF_Q0 + 5'd1], r_regs[OFF_Q0]};
  assign w_s_flat = {r_regs[OFF_S0 + 5'd4], r_regs[OFF_S0 + 5'd3], r_regs[OFF_S0 + 5'd2],
                     r_regs[OFF_S0 + 5'd1], r_regs[OFF_S0]};

  // Register file storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 29; i++) begin
        r_regs[i] <= 16'd0;
      end
    end else if (w_wr_en) begin
      r_regs[offset] <= writeData;
    end else begin
      r_regs[offset] <= r_regs[offset];
    end
  end

  // Read source selection, including the read-only result and status words.
  always_comb begin
    w_rd_mux = 16'd0;
    if (offset <= OFF_LAST) begin
      w_rd_mux = r_regs[offset];
    end else begin
      case (offset)
        OFF_RESULT: w_rd_mux = w_result;
        OFF_STATUS: w_rd_mux = {14'd0, w_done, w_busy};
        default:    w_rd_mux = 16'd0;
      endcase
    end
  end

  // Registered read data; sampling before the write commits gives old-value semantics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data <= 16'd0;
    end else if (chipselect & read) begin
      r_read_data <= w_rd_mux;
    end else begin
      r_read_data <= r_read_data;
    end
  end

  span_scan_unit u_scan (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_start),
    .i_price  (r_regs[OFF_P]),
    .i_pct    (r_regs[OFF_PCT]),
    .i_q_flat (w_q_flat),
    .i_s_flat (w_s_flat),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_range  (w_range),
    .o_result (w_result)
  );

  assign readData       = r_read_data;
  assign priceScanRange = w_range;

endmodule

// File: tb/tb_span_cme_calc.sv
// Self-checking bench for span_cme_calc: directed scenarios plus randomized portfolios vs. an arithmetic model.
module tb_span_cme_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [4:0]  offset;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic [15:0] priceScanRange;

  span_cme_calc dut (
    .clk            (clk),
    .reset          (reset),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .offset         (offset),
    .writeData      (writeData),
    .readData       (readData),
    .priceScanRange (priceScanRange)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_regs [0:28];
  logic [15:0] m_result;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_exp_r;
  logic [15:0] m_exp_res;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected range and result straight from the arithmetic definition.
  function automatic void model_calc(output logic [15:0] r_o, output logic [15:0] res_o);
    longint prod, rr, d, m, loss, mx;
    prod = longint'(m_regs[0]) * longint'(m_regs[6]);
    rr = prod / 100;
    if (rr > 65535) rr = 65535;
    d = 0;
    for (int i = 0; i < 5; i++) begin
      d += longint'($signed(m_regs[1 + i])) * longint'(m_regs[9 + i]);
    end
    mx = 0;
    for (int k = -3; k <= 3; k++) begin
      m = (longint'(k) * rr) / 3;
      loss = -d * m;
      if (loss > mx) mx = loss;
    end
    r_o = rr[15:0];
    res_o = (mx > 65535) ? 16'hFFFF : mx[15:0];
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] off);
    if (off <= 5'd28) return m_regs[off];
    else if (off == 5'd29) return m_result;
    else if (off == 5'd30) return {14'd0, m_done, m_busy};
    else return 16'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 29; i++) m_regs[i] = 16'd0;
    m_result = 16'd0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [15:0] data);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; offset = off; writeData = data;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    if (!m_busy && off <= 5'd28) begin
      m_regs[off] = data;
      if (off == 5'd28) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        model_calc(m_exp_r, m_exp_res);
      end
    end
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [15:0] data);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; offset = off;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    data = readData;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] off);
    logic [15:0] d;
    bus_read(off, d);
    check_val(tag, {16'd0, d}, {16'd0, model_read(off)});
  endtask

  task automatic load(input logic [15:0] p, input logic [15:0] pct,
                      input logic [15:0] q0, input logic [15:0] q1, input logic [15:0] q2,
                      input logic [15:0] q3, input logic [15:0] q4,
                      input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                      input logic [15:0] s3, input logic [15:0] s4);
    bus_write(5'd0, p);   bus_write(5'd6, pct);
    bus_write(5'd1, q0);  bus_write(5'd2, q1);  bus_write(5'd3, q2);
    bus_write(5'd4, q3);  bus_write(5'd5, q4);
    bus_write(5'd9, s0);  bus_write(5'd10, s1); bus_write(5'd11, s2);
    bus_write(5'd12, s3); bus_write(5'd13, s4);
  endtask

  task automatic start_and_status(input logic [15:0] v);
    logic [15:0] d;
    bus_write(5'd28, v);
    bus_read(5'd30, d);
    check_val("status_busy", {16'd0, d}, 32'd1);
  endtask

  // 'used' = edges already consumed after the start write; the 14th edge is the completion edge.
  task automatic finish_check(input int used, input logic [15:0] exp_r, input logic [15:0] exp_res);
    logic [15:0] d;
    repeat (13 - used) @(posedge clk);
    #1;
    bus_read(5'd30, d);
    check_val("status_before_done", {16'd0, d}, 32'd1);
    check_val("scan_range", {16'd0, priceScanRange}, {16'd0, exp_r});
    m_busy = 1'b0;
    m_done = 1'b1;
    m_result = exp_res;
    read_chk("result", 5'd29);
    read_chk("status_done", 5'd30);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] rq [5];
    logic [15:0] rs [5];
    logic [15:0] rp, rpct;

    chipselect = 1'b0; write = 1'b0; read = 1'b0; offset = 5'd0; writeData = 16'd0;
    reset = 1'b1;
    model_clear();
    m_exp_r = 16'd0; m_exp_res = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of every offset and the range output.
    check_val("reset_range", {16'd0, priceScanRange}, 32'd0);
    for (int off = 0; off < 32; off++) begin
      read_chk($sformatf("reset_off%0d", off), off[4:0]);
    end

    // Mixed portfolio: D=20, R=30, worst loss 600 at k=-3.
    load(16'd300, 16'd10, 16'd10, 16'd15, -16'sd5, 16'd0, 16'd0,
         16'd3, 16'd1, 16'd5, 16'd0, 16'd0);
    bus_write(5'd7, 16'h1234);
    bus_write(5'd20, 16'hBEEF);
    start_and_status(16'h0A5A);
    finish_check(1, 16'd30, 16'd600);
    read_chk("storage_off7", 5'd7);
    read_chk("storage_off20", 5'd20);
    read_chk("storage_off28", 5'd28);
    read_chk("position_q2", 5'd3);

    // Short position: worst loss at k=+3.
    load(16'd300, 16'd10, -16'sd20, 16'd0, 16'd0, 16'd0, 16'd0,
         16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    start_and_status(16'd1);
    finish_check(1, 16'd30, 16'd600);

    // Flat portfolio: no loss anywhere.
    load(16'd300, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
         16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    start_and_status(16'd2);
    finish_check(1, 16'd30, 16'd0);

    // Loss of 1e7 clamps to 0xFFFF.
    load(16'd1000, 16'd100, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0,
         16'd10, 16'd0, 16'd0, 16'd0, 16'd0);
    start_and_status(16'd3);
    finish_check(1, 16'd1000, 16'hFFFF);

    // Writes while busy (including a second start) are dropped.
    load(16'd300, 16'd10, 16'd10, 16'd15, -16'sd5, 16'd0, 16'd0,
         16'd3, 16'd1, 16'd5, 16'd0, 16'd0);
    bus_write(5'd28, 16'd1);
    bus_write(5'd1, 16'd99);
    bus_write(5'd28, 16'd2);
    finish_check(2, 16'd30, 16'd600);
    bus_read(5'd1, d);
    check_val("busy_write_ignored", {16'd0, d}, 32'd10);
    bus_read(5'd28, d);
    check_val("busy_start_ignored", {16'd0, d}, 32'd1);
    read_chk("no_restart_status", 5'd30);

    // Reset in the middle of the scenario scan.
    load(16'd500, 16'd20, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0,
         16'd4, 16'd0, 16'd0, 16'd0, 16'd0);
    bus_write(5'd28, 16'd5);
    repeat (9) @(posedge clk);
    do_reset();
    check_val("midreset_range", {16'd0, priceScanRange}, 32'd0);
    read_chk("midreset_status", 5'd30);
    read_chk("midreset_result", 5'd29);
    read_chk("midreset_p", 5'd0);
    read_chk("midreset_q0", 5'd1);
    read_chk("midreset_off28", 5'd28);

    // Randomized portfolios; even passes stay in a non-saturating range.
    for (int it = 0; it < 10; it++) begin
      if (it % 2 == 0) begin
        rp = 16'($urandom_range(0, 500));
        rpct = 16'($urandom_range(0, 20));
        for (int i = 0; i < 5; i++) begin
          rq[i] = 16'($signed($urandom_range(0, 20)) - 10);
          rs[i] = 16'($urandom_range(0, 5));
        end
      end else begin
        rp = 16'($urandom);
        rpct = 16'($urandom_range(0, 300));
        for (int i = 0; i < 5; i++) begin
          rq[i] = 16'($urandom);
          rs[i] = 16'($urandom);
        end
      end
      load(rp, rpct, rq[0], rq[1], rq[2], rq[3], rq[4], rs[0], rs[1], rs[2], rs[3], rs[4]);
      start_and_status(16'($urandom));
      finish_check(1, m_exp_r, m_exp_res);
      read_chk("rand_off28", 5'd28);
      read_chk("rand_q4", 5'd5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
